// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - request/result handshake bundle for the load align unit.
interface load_align_unit_if #(
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              i_valid;
  logic              o_ready;
  logic [OFF_W-1:0]  i_byte_offset;
  logic [1:0]        i_size;
  logic              i_signed;
  logic [DATA_W-1:0] i_rdata;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_misaligned;

  modport slave (
    input  i_valid, i_byte_offset, i_size, i_signed, i_rdata, i_ready,
    output o_ready, o_valid, o_data, o_misaligned
  );

  modport master (
    output i_valid, i_byte_offset, i_size, i_signed, i_rdata, i_ready,
    input  o_ready, o_valid, o_data, o_misaligned
  );
endinterface

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - extracts, aligns and extends a load field into a one-deep result register.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  load_align_unit_if.slave   bus,
  input  logic               i_cnt_clr,
  output logic [CNT_W-1:0]   o_misalign_cnt
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              valid_q;
  logic              mis_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;
  logic [DATA_W-1:0] field;
  logic              mis_d;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_d;

  assign ready  = !valid_q || bus.i_ready;
  assign accept = bus.i_valid && ready;

  always_comb begin
    shifted = bus.i_rdata >> {bus.i_byte_offset, 3'b000};
    mask    = '1;
    mis_d   = 1'b0;
    case (bus.i_size)
      2'b00: begin
        mask  = DATA_W'(8'hFF);
        mis_d = 1'b0;
      end
      2'b01: begin
        mask  = DATA_W'(16'hFFFF);
        mis_d = bus.i_byte_offset[0];
      end
      2'b10: begin
        mask  = DATA_W'(32'hFFFF_FFFF);
        mis_d = (bus.i_byte_offset & OFF_W'(3)) != '0;
      end
      default: begin
        mask  = '1;
        mis_d = bus.i_byte_offset != '0;
      end
    endcase
    // Field MSB is the top set bit of the mask; full-width loads never extend.
    sign   = bus.i_signed && (bus.i_size != 2'b11) && (|(shifted & mask & ~(mask >> 1)));
    field  = sign ? (shifted | ~mask) : (shifted & mask);
    data_d = mis_d ? '0 : field;

    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (accept && mis_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        valid_q <= 1'b1;
        mis_q   <= mis_d;
        data_q  <= data_d;
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_misaligned = mis_q;
  assign o_misalign_cnt  = cnt_q;
endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed self-checking bench for load_align_unit (32-bit and 64-bit instances).
module tb_load_align_unit;
  logic       clk;
  logic       rst_n;
  logic       clr_a;
  logic       clr_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  int         n_checks;
  int         n_errors;

  load_align_unit_if #(.DATA_W(32)) bus_a ();
  load_align_unit_if #(.DATA_W(64)) bus_b ();

  load_align_unit #(.DATA_W(32), .CNT_W(2)) dut_a (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus_a),
    .i_cnt_clr      (clr_a),
    .o_misalign_cnt (cnt_a)
  );

  load_align_unit #(.DATA_W(64), .CNT_W(8)) dut_b (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus_b),
    .i_cnt_clr      (clr_b),
    .o_misalign_cnt (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] off, input logic [1:0] sz,
                         input logic sg, input logic [31:0] d);
    bus_a.i_valid       = v;
    bus_a.i_byte_offset = off;
    bus_a.i_size        = sz;
    bus_a.i_signed      = sg;
    bus_a.i_rdata       = d;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] off, input logic [1:0] sz,
                         input logic sg, input logic [63:0] d);
    bus_b.i_valid       = v;
    bus_b.i_byte_offset = off;
    bus_b.i_size        = sz;
    bus_b.i_signed      = sg;
    bus_b.i_rdata       = d;
  endtask

  logic [31:0] byte_exp [4];
  logic [1:0]  mis_off  [4];
  logic [1:0]  mis_sz   [4];
  logic [1:0]  cnt_exp  [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    byte_exp = '{32'hFFFF_FFE1, 32'hFFFF_FFC3, 32'h0000_007F, 32'hFFFF_FF8A};
    mis_off  = '{2'd1, 2'd3, 2'd2, 2'd1};
    mis_sz   = '{2'b01, 2'b01, 2'b10, 2'b11};
    cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd3};

    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    drive_a(1'b0, 2'd0, 2'b00, 1'b0, 32'h0);
    drive_b(1'b0, 3'd0, 2'b00, 1'b0, 64'h0);
    bus_a.i_ready = 1'b1;
    bus_b.i_ready = 1'b1;
    #2;
    check("rst_valid", 64'(bus_a.o_valid), 64'h0);
    check("rst_data", 64'(bus_a.o_data), 64'h0);
    check("rst_mis", 64'(bus_a.o_misaligned), 64'h0);
    check("rst_cnt", 64'(cnt_a), 64'h0);
    check("rst_ready", 64'(bus_a.o_ready), 64'h1);
    tick();
    tick();
    rst_n = 1'b1;

    // Signed byte loads, back to back; first accept on the first edge after release.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 2'(i), 2'b00, 1'b1, 32'h8A7F_C3E1);
      tick();
      check($sformatf("byte_off%0d", i), 64'(bus_a.o_data), 64'(byte_exp[i]));
      check($sformatf("byte_valid%0d", i), 64'(bus_a.o_valid), 64'h1);
    end

    drive_a(1'b1, 2'd2, 2'b01, 1'b0, 32'h8A7F_C3E1);
    tick();
    check("half_off2_data", 64'(bus_a.o_data), 64'h0000_8A7F);
    check("half_off2_mis", 64'(bus_a.o_misaligned), 64'h0);
    drive_a(1'b1, 2'd1, 2'b01, 1'b0, 32'h8A7F_C3E1);
    tick();
    check("half_off1_data", 64'(bus_a.o_data), 64'h0);
    check("half_off1_mis", 64'(bus_a.o_misaligned), 64'h1);
    check("half_off1_cnt", 64'(cnt_a), 64'h1);

    // Backpressure: result held, new request blocked, then drained with no bubble.
    drive_a(1'b1, 2'd0, 2'b10, 1'b0, 32'h1234_5678);
    tick();
    check("hold_first", 64'(bus_a.o_data), 64'h1234_5678);
    bus_a.i_ready = 1'b0;
    drive_a(1'b1, 2'd1, 2'b00, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_data%0d", i), 64'(bus_a.o_data), 64'h1234_5678);
      check($sformatf("hold_valid%0d", i), 64'(bus_a.o_valid), 64'h1);
      check($sformatf("hold_ready%0d", i), 64'(bus_a.o_ready), 64'h0);
    end
    bus_a.i_ready = 1'b1;
    #1;
    check("drain_ready", 64'(bus_a.o_ready), 64'h1);
    tick();
    check("drain_data", 64'(bus_a.o_data), 64'h0000_0056);
    check("drain_valid", 64'(bus_a.o_valid), 64'h1);
    drive_a(1'b0, 2'd0, 2'b00, 1'b0, 32'h0);
    tick();
    check("idle_valid", 64'(bus_a.o_valid), 64'h0);

    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr_cnt", 64'(cnt_a), 64'h0);

    // Saturating counter with CNT_W=2.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, mis_off[i], mis_sz[i], 1'b1, 32'h8A7F_C3E1);
      tick();
      check($sformatf("sat_mis%0d", i), 64'(bus_a.o_misaligned), 64'h1);
      check($sformatf("sat_data%0d", i), 64'(bus_a.o_data), 64'h0);
      check($sformatf("sat_cnt%0d", i), 64'(cnt_a), 64'(cnt_exp[i]));
    end
    clr_a = 1'b1;
    drive_a(1'b1, 2'd3, 2'b01, 1'b0, 32'h8A7F_C3E1);
    tick();
    clr_a = 1'b0;
    check("clr_vs_inc_cnt", 64'(cnt_a), 64'h0);
    check("clr_vs_inc_mis", 64'(bus_a.o_misaligned), 64'h1);

    drive_a(1'b1, 2'd0, 2'b11, 1'b1, 32'h8A7F_C3E1);
    tick();
    check("full32_data", 64'(bus_a.o_data), 64'h8A7F_C3E1);
    check("full32_mis", 64'(bus_a.o_misaligned), 64'h0);

    // Asynchronous reset mid-cycle with a pending result and a saturated counter.
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 2'd1, 2'b01, 1'b0, 32'h8A7F_C3E1);
      tick();
    end
    check("pre_rst_cnt", 64'(cnt_a), 64'h3);
    drive_a(1'b0, 2'd0, 2'b00, 1'b0, 32'h0);
    bus_a.i_ready = 1'b0;
    #2;
    check("pre_rst_valid", 64'(bus_a.o_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus_a.o_valid), 64'h0);
    check("async_rst_data", 64'(bus_a.o_data), 64'h0);
    check("async_rst_mis", 64'(bus_a.o_misaligned), 64'h0);
    check("async_rst_cnt", 64'(cnt_a), 64'h0);
    check("async_rst_ready", 64'(bus_a.o_ready), 64'h1);
    #1;
    rst_n = 1'b1;
    bus_a.i_ready = 1'b1;
    tick();
    check("post_rst_valid", 64'(bus_a.o_valid), 64'h0);
    check("post_rst_ready", 64'(bus_a.o_ready), 64'h1);

    // 64-bit instance.
    drive_b(1'b1, 3'd4, 2'b10, 1'b1, 64'h8000_0001_FFFF_FFFE);
    tick();
    check("w64_word_off4", bus_b.o_data, 64'hFFFF_FFFF_8000_0001);
    check("w64_word_mis", 64'(bus_b.o_misaligned), 64'h0);
    drive_b(1'b1, 3'd0, 2'b11, 1'b1, 64'h8000_0001_FFFF_FFFE);
    tick();
    check("w64_full", bus_b.o_data, 64'h8000_0001_FFFF_FFFE);
    drive_b(1'b1, 3'd6, 2'b01, 1'b1, 64'h8000_0001_FFFF_FFFE);
    tick();
    check("w64_half_off6", bus_b.o_data, 64'hFFFF_FFFF_FFFF_8000);
    drive_b(1'b1, 3'd2, 2'b10, 1'b1, 64'h8000_0001_FFFF_FFFE);
    tick();
    check("w64_word_off2_mis", 64'(bus_b.o_misaligned), 64'h1);
    check("w64_word_off2_data", bus_b.o_data, 64'h0);
    check("w64_cnt", 64'(cnt_b), 64'h1);
    drive_b(1'b0, 3'd0, 2'b00, 1'b0, 64'h0);
    tick();
    check("w64_idle_valid", 64'(bus_b.o_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter DATA_W, default 32; load data width in bits; legal values 32 or 64.
REQ-002 Parameter CNT_W, default 8; width of the misaligned-access counter.
REQ-003 Derived constant OFF_W = log2(DATA_W/8); byte-offset width (2 for 32, 3 for 64).
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  upstream request valid.
REQ-007 o_ready  output  1  unit can accept a request this cycle.
REQ-008 i_byte_offset  input  OFF_W  byte address of the access within i_rdata.
REQ-009 i_size  input  2  access size: 00 byte, 01 half, 10 word (32 b), 11 full DATA_W.
REQ-010 i_signed  input  1  1 = sign-extend, 0 = zero-extend.
REQ-011 i_rdata  input  DATA_W  raw memory read word.
REQ-012 o_valid  output  1  result register holds a valid result.
REQ-013 i_ready  input  1  downstream accepts the result.
REQ-014 o_data  output  DATA_W  aligned, extended result.
REQ-015 o_misaligned  output  1  result beat is a misaligned/illegal access.
REQ-016 i_cnt_clr  input  1  synchronous clear of the misaligned counter.
REQ-017 o_misalign_cnt  output  CNT_W  saturating count of misaligned accepted requests.

Function
REQ-018 Accept a request when i_valid && o_ready; o_ready SHALL equal !o_valid || i_ready (combinational).
REQ-019 Latency SHALL be exactly one cycle: accepted request appears on o_data/o_valid the next edge.
REQ-020 Result register SHALL hold o_data, o_misaligned and o_valid stable while o_valid && !i_ready.
REQ-021 o_valid clears on i_ready with no new accept; back-to-back accept-and-drain SHALL sustain one result per cycle.
REQ-022 Field select: size bytes starting at byte i_byte_offset, i.e. bits [8*off +: 8*bytes]; bytes = 1, 2, 4, DATA_W/8.
REQ-023 Extension: upper bits SHALL be filled with the field MSB when i_signed=1, with 0 when i_signed=0; size 11 ignores i_signed.
REQ-024 Misaligned when i_byte_offset is not a multiple of the access byte count, or when size 10 with DATA_W=32 and offset!=0, or size 11 with offset!=0.
REQ-025 Misaligned accepted request SHALL produce o_data=0, o_misaligned=1, o_valid=1 (still one beat, still handshaken).
REQ-026 Counter SHALL increment by 1 on each accepted misaligned request, saturating at 2^CNT_W-1 with no wrap.
REQ-027 i_cnt_clr SHALL set the counter to 0 next edge; clear takes precedence over a simultaneous increment (that event is not counted).
REQ-028 Requests with i_valid=0 or o_ready=0 SHALL not change the counter or result register.

Reset
REQ-029 On i_rst_n low, immediately and asynchronously: o_valid=0, o_data=0, o_misaligned=0, o_misalign_cnt=0.
REQ-030 o_ready SHALL read 1 while in reset and after release with o_valid=0.
REQ-031 Reset asserted with a result pending SHALL discard it; no beat is delivered after release.
REQ-032 First accept is permitted on the first rising edge after i_rst_n deasserts.

Verification
REQ-033 DATA_W=32, i_rdata=0x8A7F_C3E1, size 00, signed 1, offsets 0..3 -> o_data 0xFFFFFFE1, 0xFFFFFFC3, 0x0000007F, 0xFFFFFF8A one cycle after each accept.
REQ-034 Same data, size 01, signed 0, offset 2 -> 0x00008A7F, o_misaligned=0; offset 1 -> o_data=0, o_misaligned=1, counter 0->1.
REQ-035 DATA_W=64, i_rdata=0x8000_0001_FFFF_FFFE, size 10, signed 1, offset 4 -> 0xFFFFFFFF80000001; size 11, offset 0 -> full word unchanged.
REQ-036 Hold i_ready=0 for 3 cycles with o_valid=1 -> o_data stable, o_ready=0, new i_valid not accepted; i_ready=1 plus i_valid -> next result next edge, no bubble.
REQ-037 CNT_W=2, four misaligned accepts -> counter 1,2,3,3; i_cnt_clr coincident with a fifth misaligned accept -> counter 0.
REQ-038 Assert i_rst_n=0 mid-cycle with o_valid=1 and counter 3 -> outputs 0 immediately; after release o_ready=1, no stale beat.
